// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: ALUControl encodings and FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;
    localparam logic [2:0] ALU_RSV = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per step, low WIDTH bits of the product.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_sum;

    // product already includes the partial product of the current step,
    // so the final step can hand it straight to the result register
    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign product = acc_sum;
    assign last    = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-edge logic/arith ops, WIDTH-edge shift-add multiply.
// Multiply is built only when ALU_MC_MUL_EN is defined; otherwise code 110 returns 0.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quick_res;

    // reserved code (and mul when not built) falls through to 0
    always_comb begin
        quick_res = '0;
        case (ALUControl)
            ALU_ADD: quick_res = SrcA + SrcB;
            ALU_SUB: quick_res = SrcA - SrcB;
            ALU_AND: quick_res = SrcA & SrcB;
            ALU_OR:  quick_res = SrcA | SrcB;
            ALU_XOR: quick_res = SrcA ^ SrcB;
            ALU_SLT: quick_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: quick_res = '0;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    alu_state_t       state_q, state_d;
    logic             busy_q, busy_d;
    logic             mul_load, mul_step, mul_last;
    logic [WIDTH-1:0] mul_prod;

    mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
        .clk     (clk),
        .rst     (reset),
        .load    (mul_load),
        .step    (mul_step),
        .a       (SrcA),
        .b       (SrcB),
        .last    (mul_last),
        .product (mul_prod)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (ALUControl == ALU_MUL) begin
                        state_d  = ST_MUL;
                        busy_d   = 1'b1;
                        mul_load = 1'b1;
                    end else begin
                        result_d = quick_res;
                        zero_d   = (quick_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    result_d = mul_prod;
                    zero_d   = (mul_prod == '0);
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = busy_q;
`else
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        if (start) begin
            result_d = quick_res;
            zero_d   = (quick_res == '0);
            done_d   = 1'b1;
        end
    end

    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef ALU_MC_MUL_EN
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
`endif
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
`ifdef ALU_MC_MUL_EN
            state_q  <= state_d;
            busy_q   <= busy_d;
`endif
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign done      = done_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values 8 to 64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; operands and ALUControl are sampled on the rising edge where start=1 and busy=0.
REQ-005 ALUControl  input  3  operation code from the ALU decoder.
REQ-006 SrcA  input  WIDTH  operand A.
REQ-007 SrcB  input  WIDTH  operand B.
REQ-008 ALUResult  output  WIDTH  registered result; holds its value until the next done.
REQ-009 Zero  output  1  registered flag, 1 when ALUResult equals 0.
REQ-010 busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 done  output  1  single-cycle pulse marking a new valid ALUResult and Zero.

Function
REQ-012 Encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 mul, 111 reserved.
REQ-013 add, sub and mul results wrap modulo 2^WIDTH; mul returns the low WIDTH bits of the product.
REQ-014 slt compares SrcA and SrcB as two's-complement values and returns 1 when SrcA < SrcB, else 0, zero-extended to WIDTH bits.
REQ-015 Reserved code 111 returns 0 with the single-cycle latency.
REQ-016 FSM states: IDLE and MUL.
REQ-017 IDLE, accepted start with a non-mul code: stay in IDLE; ALUResult, Zero and done=1 update on that same edge, giving a latency of 1 edge.
REQ-018 IDLE, accepted start with code 110: go to MUL on that edge, load the shift-add datapath, and clear the iteration counter.
REQ-019 MUL: consume one multiplier bit per edge for exactly WIDTH edges; on the final edge return to IDLE and update ALUResult and Zero with done=1. Latency is WIDTH edges after the accepting edge.
REQ-020 busy=1 exactly while the state is MUL; busy=0 in the cycle in which done=1.
REQ-021 start while busy=1 is ignored; there is no queueing and operands are not re-sampled.
REQ-022 start asserted in the cycle in which done=1 (state IDLE) is accepted normally, allowing back-to-back operations.
REQ-023 done is 0 in every cycle not listed above, and ALUResult and Zero do not change without done.
REQ-024 Operand changes after the accepting edge have no effect on an in-flight mul.

Reset
REQ-025 reset=1 forces, asynchronously: state IDLE, ALUResult=0, Zero=1, busy=0, done=0, iteration counter 0.
REQ-026 reset asserted during MUL aborts the operation; no done is produced for it after reset is released.
REQ-027 Operation restarts on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro ALU_MC_MUL_EN defined: mul behaves per REQ-018 to REQ-020.
REQ-029 Macro ALU_MC_MUL_EN undefined: the MUL state, counter and datapath are not built; code 110 behaves like 111 (result 0, 1-edge latency) and busy is tied to 0.

Structure
REQ-030 Shared package alu_pkg holds the ALUControl encoding constants and the FSM state enum; alu_mc and the ALU decoder both import it.
REQ-031 The shift-add multiplier datapath (accumulator, shifted multiplicand, multiplier shift register, counter) is one sub-module, mul_iter, instantiated only under ALU_MC_MUL_EN.

Verification
REQ-032 The bench shall cover the following directed scenarios with WIDTH=32:
- add 0xFFFFFFFF+1 -> 1 edge later done=1, ALUResult=0, Zero=1.
- slt with SrcA=0xFFFFFFFE (-2), SrcB=1 -> ALUResult=1; swapping the operands -> ALUResult=0, Zero=1.
- mul 0x00010003 x 0x00020005 -> busy for 32 cycles, done on edge 32, ALUResult=0x000B000F; start pulses during busy ignored.
- mul immediately followed by start(sub 7-9) in the done cycle -> next edge ALUResult=0xFFFFFFFE, done=1.
- reset asserted at cycle 10 of a mul -> outputs immediately at reset values, no done after release.
- With ALU_MC_MUL_EN undefined: mul 3x4 -> 1 edge later ALUResult=0, busy never asserted.
